// File: rtl/bcd_seg_scan4_if.sv
// ============================================================================
// Module      : bcd_seg_scan4_if
// Description : BCD snapshot input and multiplexed 7-segment output bundle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bcd_seg_scan4_if;
    logic [15:0] digits;
    logic        load;
    logic [6:0]  seg;
    logic [3:0]  dig_sel;
    logic        frame;

    modport master (
        output digits,
        output load,
        input  seg,
        input  dig_sel,
        input  frame
    );

    modport slave (
        input  digits,
        input  load,
        output seg,
        output dig_sel,
        output frame
    );
endinterface

`default_nettype wire

// File: rtl/bcd_seg_scan4.sv
// ============================================================================
// Module      : bcd_seg_scan4
// Description : Four-digit BCD snapshot scanner for a common-anode display.
//               Optional leading-zero blanking via macro SEGSCAN_LZB_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_seg_scan4 #(
    parameter int PRESCALE = 4
) (
    input  wire              clock,
    input  wire              reset,
    bcd_seg_scan4_if.slave   bus
);

    localparam int                   c_PW         = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam logic [c_PW-1:0]      c_PRESC_MAX  = c_PW'(PRESCALE - 1);
    localparam logic [6:0]           c_SEG_BLANK  = 7'h7F;
    localparam logic [3:0]           c_SEL_OFF    = 4'hF;

    logic [c_PW-1:0] r_presc;
    logic [1:0]      r_idx;
    logic [15:0]     r_snap;
    logic [6:0]      r_seg;
    logic [3:0]      r_dig_sel;
    logic            r_frame;

    logic            w_tick;
    logic [3:0]      w_cur;
    logic            w_lz_blank;
    logic [6:0]      w_seg_next;

    function automatic logic [6:0] f_dec(input logic [3:0] i_bcd);
        logic [6:0] v;
        case (i_bcd)
            4'd0:    v = 7'h40;
            4'd1:    v = 7'h79;
            4'd2:    v = 7'h24;
            4'd3:    v = 7'h30;
            4'd4:    v = 7'h19;
            4'd5:    v = 7'h12;
            4'd6:    v = 7'h02;
            4'd7:    v = 7'h78;
            4'd8:    v = 7'h00;
            4'd9:    v = 7'h10;
            default: v = 7'h7F;
        endcase
        return v;
    endfunction

    assign w_tick = (r_presc == c_PRESC_MAX);

    always_comb begin
        w_cur = 4'h0;
        case (r_idx)
            2'd0: w_cur = r_snap[3:0];
            2'd1: w_cur = r_snap[7:4];
            2'd2: w_cur = r_snap[11:8];
            2'd3: w_cur = r_snap[15:12];
            default: w_cur = 4'h0;
        endcase
    end

`ifdef SEGSCAN_LZB_EN
    // A digit is a leading zero when it and every more significant digit are 0.
    always_comb begin
        w_lz_blank = 1'b0;
        case (r_idx)
            2'd3: w_lz_blank = (r_snap[15:12] == 4'h0);
            2'd2: w_lz_blank = (r_snap[15:8]  == 8'h00);
            2'd1: w_lz_blank = (r_snap[15:4]  == 12'h000);
            default: w_lz_blank = 1'b0;
        endcase
    end
`else
    assign w_lz_blank = 1'b0;
`endif

    assign w_seg_next = w_lz_blank ? c_SEG_BLANK : f_dec(w_cur);

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_presc   <= '0;
            r_idx     <= 2'd0;
            r_snap    <= 16'h0000;
            r_seg     <= c_SEG_BLANK;
            r_dig_sel <= c_SEL_OFF;
            r_frame   <= 1'b0;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + c_PW'(1);
            if (bus.load) begin
                r_snap <= bus.digits;
            end
            // The tick cycle is the blank gap between slots; frame marks the end of digit3.
            if (w_tick) begin
                r_idx     <= r_idx + 2'd1;
                r_seg     <= c_SEG_BLANK;
                r_dig_sel <= c_SEL_OFF;
                r_frame   <= (r_idx == 2'd3);
            end else begin
                r_seg     <= w_seg_next;
                r_dig_sel <= ~(4'b0001 << r_idx);
                r_frame   <= 1'b0;
            end
        end
    end

    assign bus.seg     = r_seg;
    assign bus.dig_sel = r_dig_sel;
    assign bus.frame   = r_frame;

endmodule

`default_nettype wire

// File: tb/tb_bcd_seg_scan4.sv
// ============================================================================
// Module      : tb_bcd_seg_scan4
// Description : Randomized self-checking bench for bcd_seg_scan4 (PRESCALE=4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bcd_seg_scan4;

    localparam int P = 4;

    logic clock = 1'b0;
    logic reset = 1'b0;

    bcd_seg_scan4_if u_if ();

    bcd_seg_scan4 #(.PRESCALE(P)) u_dut (
        .clock (clock),
        .reset (reset),
        .bus   (u_if.slave)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: time since release, snapshot value, expected outputs after the edge
    int          m_t    = 0;
    logic [15:0] m_snap = 16'h0000;
    logic [6:0]  e_seg;
    logic [3:0]  e_sel;
    logic        e_frame;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    function automatic logic [6:0] ref_dec(input int slot, input logic [15:0] s);
        logic [6:0] tab [10];
        logic [15:0] hi;
        int v;
        tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        hi = s >> (4 * slot);
        v  = int'(hi & 16'h000F);
`ifdef SEGSCAN_LZB_EN
        if (slot > 0 && hi == 16'h0000) return 7'h7F;
`endif
        if (v > 9) return 7'h7F;
        return tab[v];
    endfunction

    task automatic step(input bit rst_n, input bit ld, input logic [15:0] dg);
        int slot;
        int pos;
        @(negedge clock);
        reset       = rst_n;
        u_if.load   = ld;
        u_if.digits = dg;
        @(posedge clock);
        if (!rst_n) begin
            e_seg   = 7'h7F;
            e_sel   = 4'hF;
            e_frame = 1'b0;
            m_snap  = 16'h0000;
            m_t     = 0;
        end else begin
            slot = (m_t / P) % 4;
            pos  = m_t % P;
            if (pos == P - 1) begin
                e_seg   = 7'h7F;
                e_sel   = 4'hF;
                e_frame = (slot == 3);
            end else begin
                e_seg   = ref_dec(slot, m_snap);
                e_sel   = ~(4'b0001 << slot);
                e_frame = 1'b0;
            end
            if (ld) m_snap = dg;
            m_t++;
        end
        #1;
        check("seg",     32'(u_if.seg),     32'(e_seg));
        check("dig_sel", 32'(u_if.dig_sel), 32'(e_sel));
        check("frame",   32'(u_if.frame),   32'(e_frame));
    endtask

    function automatic logic [15:0] rand_digits();
        logic [15:0] d;
        d = 16'($urandom);
        for (int k = 0; k < 4; k++) begin
            if ($urandom_range(0, 2) == 0) d[4*k +: 4] = 4'h0;
            else if ($urandom_range(0, 3) != 0) d[4*k +: 4] = 4'($urandom_range(0, 9));
        end
        return d;
    endfunction

    initial begin
        u_if.load   = 1'b0;
        u_if.digits = 16'h0000;

        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 16'h9999);

        step(1'b1, 1'b1, 16'h1234);
        for (int i = 0; i < 40; i++) step(1'b1, 1'b0, 16'h0000);

        step(1'b1, 1'b1, 16'h00A0);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 16'h0000);

        step(1'b1, 1'b1, 16'h0045);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 16'h0000);

        step(1'b1, 1'b1, 16'h0000);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 16'h0000);

        step(1'b1, 1'b1, 16'h8888);
        for (int i = 0; i < 20; i++) begin
            if (((m_t / P) % 4) == 2 && (m_t % P) == 1) break;
            step(1'b1, 1'b0, 16'h0000);
        end
        step(1'b0, 1'b0, 16'h0000);
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 16'h0000);

        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(0, 199) != 0), ($urandom_range(0, 11) == 0), rand_digits());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
